ce_set_arbiter: RTL

- Round-robin arbiter sharing one WIDTH-bit falling-edge register bank (DFFNSE-style: CLK, CE, SET, D, Q) among NUM_REQ requesters.
- Each requester issues read, write or preset.
- The block sequences the register's CE/SET/D so that exactly one access is in flight at any time.
- Captured Q is returned with a one-cycle ACK.
- Controller runs on rising CLK; the shared register captures on the falling edge inside the access cycle.

---
 rtl/ce_set_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ce_set_arbiter.sv
// Round-robin arbiter that serialises read/write/preset accesses from NUM_REQ
// requesters onto one shared falling-edge register bank (CE/SET/D/Q).
module ce_set_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [2*NUM_REQ-1:0]     OP,
    input  logic [WIDTH*NUM_REQ-1:0] WDATA,
    output logic [NUM_REQ-1:0]       GNT,
    output logic [NUM_REQ-1:0]       ACK,
    output logic [WIDTH-1:0]         RDATA,
    output logic                     REG_CE,
    output logic                     REG_SET,
    output logic [WIDTH-1:0]         REG_D,
    input  logic [WIDTH-1:0]         REG_Q
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACCESS, ACKNOWLEDGE} state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        last_reg, last_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic [WIDTH-1:0]     rdata_reg, rdata_next;
    logic                 ce_reg, ce_next;
    logic                 set_reg, set_next;
    logic [WIDTH-1:0]     d_reg, d_next;

    logic [1:0]           op_slot    [NUM_REQ];
    logic [WIDTH-1:0]     wdata_slot [NUM_REQ];
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign op_slot[gi]    = OP[2*gi +: 2];
            assign wdata_slot[gi] = WDATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest so the first requester after LAST wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int            idx;
            logic [IW-1:0] cand;
            idx = int'(last_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IW'(idx);
            if (REQ[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        gnt_next   = gnt_reg;
        ack_next   = ack_reg;
        rdata_next = rdata_reg;
        ce_next    = ce_reg;
        set_next   = set_reg;
        d_next     = d_reg;
        case (state_reg)
            IDLE: begin
                ce_next  = 1'b0;
                set_next = 1'b0;
                if (pick_valid) begin
                    state_next         = ACCESS;
                    last_next          = pick_idx;
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    ce_next            = (op_slot[pick_idx] == 2'b01);
                    set_next           = (op_slot[pick_idx] == 2'b10);
                    d_next             = wdata_slot[pick_idx];
                end
            end
            ACCESS: begin
                // Register captured on the falling edge inside this cycle.
                rdata_next = REG_Q;
                ack_next   = gnt_reg;
                ce_next    = 1'b0;
                set_next   = 1'b0;
                state_next = ACKNOWLEDGE;
            end
            ACKNOWLEDGE: begin
                ack_next   = '0;
                gnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            last_reg  <= IW'(NUM_REQ - 1);
            gnt_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            ce_reg    <= 1'b0;
            set_reg   <= 1'b0;
            d_reg     <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            ce_reg    <= ce_next;
            set_reg   <= set_next;
            d_reg     <= d_next;
        end
    end

    assign GNT     = gnt_reg;
    assign ACK     = ack_reg;
    assign RDATA   = rdata_reg;
    assign REG_CE  = ce_reg;
    assign REG_SET = set_reg;
    assign REG_D   = d_reg;
endmodule
